// File: rtl/sound_sequencer_if.sv
// Event and speaker signals between the game controller and the sound sequencer.
// The master drives game events, the slave drives the speaker and status outputs.
interface sound_sequencer_if;
  logic       sound_en;
  logic       hit;
  logic       wall;
  logic       goal;
  logic       p1_win;
  logic       p2_win;
  logic       speaker;
  logic       busy;
  logic [2:0] sound_id;
  logic [1:0] note_idx;

  modport master (
    output sound_en, hit, wall, goal, p1_win, p2_win,
    input  speaker, busy, sound_id, note_idx
  );

  modport slave (
    input  sound_en, hit, wall, goal, p1_win, p2_win,
    output speaker, busy, sound_id, note_idx
  );
endinterface

// File: rtl/sound_sequencer.sv
// Shares one piezo output between game sound events: fixed-priority arbitration,
// a pending queue for lower classes, and timed square-wave tones (win = 4-note melody).
//
// state | meaning
// IDLE  | no sound active
// PLAY  | tone output for the current note
// GAP   | silent interval between win-melody notes
module sound_sequencer #(
  parameter int unsigned HIT_HALF  = 56818,
  parameter int unsigned WALL_HALF = 113636,
  parameter int unsigned GOAL_HALF = 37879,
  parameter int unsigned SHORT_DUR = 2500000,
  parameter int unsigned LONG_DUR  = 10000000,
  parameter int unsigned NOTE_DUR  = 7500000,
  parameter int unsigned GAP_DUR   = 1250000
) (
  input  logic              clk,
  input  logic              rst,
  sound_sequencer_if.slave  sif
);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

  localparam logic [31:0] LP_GAP_LAST = 32'(GAP_DUR - 1);

  state_t      r_state, w_state;
  logic [2:0]  r_class, w_class;
  logic [1:0]  r_note, w_note;
  logic [31:0] r_tone, w_tone;
  logic [31:0] r_dur, w_dur;
  logic        r_spk, w_spk;
  logic [3:0]  r_pend, w_pend;
  logic        r_win_d;

  logic        w_win_lvl;
  logic [3:0]  w_req;
  logic [3:0]  w_cand;
  logic [2:0]  w_req_cls;
  logic [2:0]  w_cand_cls;
  logic [31:0] w_half;
  logic [31:0] w_dur_len;

  // Bit i of a request/pending vector stands for sound class i+1.
  function automatic logic [2:0] f_prio(input logic [3:0] v);
    logic [2:0] c;
    c = 3'd0;
    if (v[0]) c = 3'd1;
    if (v[1]) c = 3'd2;
    if (v[2]) c = 3'd3;
    if (v[3]) c = 3'd4;
    return c;
  endfunction

  function automatic logic [3:0] f_onehot(input logic [2:0] c);
    logic [3:0] m;
    m = 4'b0000;
    case (c)
      3'd1:    m = 4'b0001;
      3'd2:    m = 4'b0010;
      3'd3:    m = 4'b0100;
      3'd4:    m = 4'b1000;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  assign w_win_lvl  = sif.p1_win | sif.p2_win;
  assign w_req      = sif.sound_en ? {w_win_lvl & ~r_win_d, sif.goal, sif.hit, sif.wall} : 4'b0000;
  assign w_cand     = r_pend | w_req;
  assign w_req_cls  = f_prio(w_req);
  assign w_cand_cls = f_prio(w_cand);

  always_comb begin
    w_half = 32'(HIT_HALF);
    case (r_class)
      3'd1: w_half = 32'(WALL_HALF);
      3'd2: w_half = 32'(HIT_HALF);
      3'd3: w_half = 32'(GOAL_HALF);
      3'd4: begin
        case (r_note)
          2'd0:    w_half = 32'(WALL_HALF);
          2'd1:    w_half = 32'(HIT_HALF);
          2'd2:    w_half = 32'(GOAL_HALF);
          default: w_half = 32'(HIT_HALF / 2);
        endcase
      end
      default: w_half = 32'(HIT_HALF);
    endcase
  end

  always_comb begin
    w_dur_len = 32'(SHORT_DUR);
    case (r_class)
      3'd3:    w_dur_len = 32'(LONG_DUR);
      3'd4:    w_dur_len = 32'(NOTE_DUR);
      default: w_dur_len = 32'(SHORT_DUR);
    endcase
  end

  always_comb begin
    w_state = r_state;
    w_class = r_class;
    w_note  = r_note;
    w_tone  = r_tone;
    w_dur   = r_dur;
    w_spk   = r_spk;
    w_pend  = r_pend;

    if (!sif.sound_en) begin
      w_state = S_IDLE;
      w_class = 3'd0;
      w_note  = 2'd0;
      w_tone  = 32'd0;
      w_dur   = 32'd0;
      w_spk   = 1'b0;
      w_pend  = 4'b0000;
    end else if (r_state == S_IDLE) begin
      if (|w_cand) begin
        w_state = S_PLAY;
        w_class = w_cand_cls;
        w_note  = 2'd0;
        w_tone  = 32'd0;
        w_dur   = 32'd0;
        w_spk   = 1'b0;
        w_pend  = w_cand & ~f_onehot(w_cand_cls);
      end
    end else if ((|w_req) && (w_req_cls >= r_class)) begin
      // Preempt or retrigger wins over completion in the same cycle.
      w_state = S_PLAY;
      w_class = w_req_cls;
      w_note  = 2'd0;
      w_tone  = 32'd0;
      w_dur   = 32'd0;
      w_spk   = 1'b0;
      w_pend  = (r_pend | w_req) & ~f_onehot(w_req_cls);
    end else begin
      w_pend = r_pend | w_req;
      if (r_state == S_PLAY) begin
        if (r_tone == w_half - 32'd1) begin
          w_tone = 32'd0;
          w_spk  = ~r_spk;
        end else begin
          w_tone = r_tone + 32'd1;
        end
        if (r_dur == w_dur_len - 32'd1) begin
          w_tone = 32'd0;
          w_dur  = 32'd0;
          w_spk  = 1'b0;
          if ((r_class == 3'd4) && (r_note != 2'd3)) begin
            w_state = S_GAP;
          end else begin
            w_state = S_IDLE;
            w_class = 3'd0;
            w_note  = 2'd0;
          end
        end else begin
          w_dur = r_dur + 32'd1;
        end
      end else begin
        w_spk = 1'b0;
        if (r_dur == LP_GAP_LAST) begin
          w_state = S_PLAY;
          w_note  = r_note + 2'd1;
          w_dur   = 32'd0;
          w_tone  = 32'd0;
        end else begin
          w_dur = r_dur + 32'd1;
        end
      end
    end
  end

  // win_d tracks the level even while muted so a mid-mute rise never fires later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_class <= 3'd0;
      r_note  <= 2'd0;
      r_tone  <= 32'd0;
      r_dur   <= 32'd0;
      r_spk   <= 1'b0;
      r_pend  <= 4'b0000;
      r_win_d <= 1'b0;
    end else begin
      r_state <= w_state;
      r_class <= w_class;
      r_note  <= w_note;
      r_tone  <= w_tone;
      r_dur   <= w_dur;
      r_spk   <= w_spk;
      r_pend  <= w_pend;
      r_win_d <= w_win_lvl;
    end
  end

  assign sif.speaker  = r_spk;
  assign sif.busy     = (r_state != S_IDLE);
  assign sif.sound_id = r_class;
  assign sif.note_idx = r_note;

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed bench for sound_sequencer with shortened tone/duration parameters:
// table-driven event scenarios plus hand-written melody, reset and mute sequences.
module tb_sound_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sound_sequencer_if sif();

  sound_sequencer #(
    .HIT_HALF(4), .WALL_HALF(8), .GOAL_HALF(3),
    .SHORT_DUR(20), .LONG_DUR(40), .NOTE_DUR(16), .GAP_DUR(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sif(sif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         scn;
    int         cyc;
    logic [2:0] ev;    // {goal, hit, wall} pulses driven in this cycle
    logic       busy;
    logic [2:0] id;
    logic       spk;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int c, input logic busy,
                         input logic [2:0] id, input logic spk, input logic [1:0] note);
    chk($sformatf("%s c%0d busy", tag, c), int'(sif.busy), int'(busy));
    chk($sformatf("%s c%0d sound_id", tag, c), int'(sif.sound_id), int'(id));
    chk($sformatf("%s c%0d speaker", tag, c), int'(sif.speaker), int'(spk));
    chk($sformatf("%s c%0d note_idx", tag, c), int'(sif.note_idx), int'(note));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic win);
    rst          = 1'b1;
    sif.sound_en = 1'b1;
    sif.hit      = 1'b0;
    sif.wall     = 1'b0;
    sif.goal     = 1'b0;
    sif.p1_win   = win;
    sif.p2_win   = 1'b0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // scn 0: single hit at cycle 10
    vecs.push_back('{0, 10, 3'b010, 1'b0, 3'd0, 1'b0});
    vecs.push_back('{0, 11, 3'b000, 1'b1, 3'd2, 1'b0});
    vecs.push_back('{0, 14, 3'b000, 1'b1, 3'd2, 1'b0});
    vecs.push_back('{0, 15, 3'b000, 1'b1, 3'd2, 1'b1});
    vecs.push_back('{0, 19, 3'b000, 1'b1, 3'd2, 1'b0});
    vecs.push_back('{0, 23, 3'b000, 1'b1, 3'd2, 1'b1});
    vecs.push_back('{0, 27, 3'b000, 1'b1, 3'd2, 1'b0});
    vecs.push_back('{0, 30, 3'b000, 1'b1, 3'd2, 1'b0});
    vecs.push_back('{0, 31, 3'b000, 1'b0, 3'd0, 1'b0});
    vecs.push_back('{0, 33, 3'b000, 1'b0, 3'd0, 1'b0});
    // scn 1: wall then goal preempts; wall dropped
    vecs.push_back('{1, 2,  3'b001, 1'b0, 3'd0, 1'b0});
    vecs.push_back('{1, 3,  3'b000, 1'b1, 3'd1, 1'b0});
    vecs.push_back('{1, 7,  3'b100, 1'b1, 3'd1, 1'b0});
    vecs.push_back('{1, 8,  3'b000, 1'b1, 3'd3, 1'b0});
    vecs.push_back('{1, 11, 3'b000, 1'b1, 3'd3, 1'b1});
    vecs.push_back('{1, 47, 3'b000, 1'b1, 3'd3, 1'b1});
    vecs.push_back('{1, 48, 3'b000, 1'b0, 3'd0, 1'b0});
    vecs.push_back('{1, 60, 3'b000, 1'b0, 3'd0, 1'b0});
    // scn 2: goal, then hit and wall queue behind it
    vecs.push_back('{2, 2,  3'b100, 1'b0, 3'd0, 1'b0});
    vecs.push_back('{2, 10, 3'b010, 1'b1, 3'd3, 1'b0});
    vecs.push_back('{2, 15, 3'b001, 1'b1, 3'd3, 1'b0});
    vecs.push_back('{2, 42, 3'b000, 1'b1, 3'd3, 1'b1});
    vecs.push_back('{2, 43, 3'b000, 1'b0, 3'd0, 1'b0});
    vecs.push_back('{2, 44, 3'b000, 1'b1, 3'd2, 1'b0});
    vecs.push_back('{2, 63, 3'b000, 1'b1, 3'd2, 1'b0});
    vecs.push_back('{2, 64, 3'b000, 1'b0, 3'd0, 1'b0});
    vecs.push_back('{2, 65, 3'b000, 1'b1, 3'd1, 1'b0});
    vecs.push_back('{2, 84, 3'b000, 1'b1, 3'd1, 1'b0});
    vecs.push_back('{2, 85, 3'b000, 1'b0, 3'd0, 1'b0});
    vecs.push_back('{2, 88, 3'b000, 1'b0, 3'd0, 1'b0});
    // scn 3: wall, hit, goal together while idle
    vecs.push_back('{3, 2,  3'b111, 1'b0, 3'd0, 1'b0});
    vecs.push_back('{3, 3,  3'b000, 1'b1, 3'd3, 1'b0});
    vecs.push_back('{3, 42, 3'b000, 1'b1, 3'd3, 1'b1});
    vecs.push_back('{3, 43, 3'b000, 1'b0, 3'd0, 1'b0});
    vecs.push_back('{3, 44, 3'b000, 1'b1, 3'd2, 1'b0});
    vecs.push_back('{3, 63, 3'b000, 1'b1, 3'd2, 1'b0});
    vecs.push_back('{3, 64, 3'b000, 1'b0, 3'd0, 1'b0});
    vecs.push_back('{3, 65, 3'b000, 1'b1, 3'd1, 1'b0});
    vecs.push_back('{3, 84, 3'b000, 1'b1, 3'd1, 1'b0});
    vecs.push_back('{3, 85, 3'b000, 1'b0, 3'd0, 1'b0});
    // scn 4: hit retriggered mid-sound restarts counters
    vecs.push_back('{4, 2,  3'b010, 1'b0, 3'd0, 1'b0});
    vecs.push_back('{4, 12, 3'b010, 1'b1, 3'd2, 1'b0});
    vecs.push_back('{4, 13, 3'b000, 1'b1, 3'd2, 1'b0});
    vecs.push_back('{4, 15, 3'b000, 1'b1, 3'd2, 1'b0});
    vecs.push_back('{4, 17, 3'b000, 1'b1, 3'd2, 1'b1});
    vecs.push_back('{4, 32, 3'b000, 1'b1, 3'd2, 1'b0});
    vecs.push_back('{4, 33, 3'b000, 1'b0, 3'd0, 1'b0});

    for (int s = 0; s < 5; s++) begin
      int maxc;
      maxc = 0;
      foreach (vecs[i]) if (vecs[i].scn == s && vecs[i].cyc > maxc) maxc = vecs[i].cyc;
      do_reset(1'b0);
      for (int c = 0; c <= maxc; c++) begin
        logic [2:0] ev;
        ev = 3'b000;
        foreach (vecs[i]) begin
          if (vecs[i].scn == s && vecs[i].cyc == c) begin
            ev = ev | vecs[i].ev;
            chk_out($sformatf("scn%0d", s), c, vecs[i].busy, vecs[i].id, vecs[i].spk, 2'd0);
          end
        end
        sif.wall = ev[0];
        sif.hit  = ev[1];
        sif.goal = ev[2];
        tick;
      end
      sif.wall = 1'b0;
      sif.hit  = 1'b0;
      sif.goal = 1'b0;
    end

    // Win melody: p1_win held from cycle 5
    do_reset(1'b0);
    chk_out("reset", 0, 1'b0, 3'd0, 1'b0, 2'd0);
    for (int c = 0; c <= 95; c++) begin
      if (c == 5) sif.p1_win = 1'b1;
      case (c)
        5:  chk_out("win", c, 1'b0, 3'd0, 1'b0, 2'd0);
        6:  chk_out("win", c, 1'b1, 3'd4, 1'b0, 2'd0);
        13: chk_out("win", c, 1'b1, 3'd4, 1'b0, 2'd0);
        14: chk_out("win", c, 1'b1, 3'd4, 1'b1, 2'd0);
        21: chk_out("win", c, 1'b1, 3'd4, 1'b1, 2'd0);
        22: chk_out("win", c, 1'b1, 3'd4, 1'b0, 2'd0);
        25: chk_out("win", c, 1'b1, 3'd4, 1'b0, 2'd0);
        26: chk_out("win", c, 1'b1, 3'd4, 1'b0, 2'd1);
        30: chk_out("win", c, 1'b1, 3'd4, 1'b1, 2'd1);
        41: chk_out("win", c, 1'b1, 3'd4, 1'b1, 2'd1);
        42: chk_out("win", c, 1'b1, 3'd4, 1'b0, 2'd1);
        46: chk_out("win", c, 1'b1, 3'd4, 1'b0, 2'd2);
        49: chk_out("win", c, 1'b1, 3'd4, 1'b1, 2'd2);
        66: chk_out("win", c, 1'b1, 3'd4, 1'b0, 2'd3);
        67: chk_out("win", c, 1'b1, 3'd4, 1'b0, 2'd3);
        68: chk_out("win", c, 1'b1, 3'd4, 1'b1, 2'd3);
        81: chk_out("win", c, 1'b1, 3'd4, 1'b1, 2'd3);
        82: chk_out("win", c, 1'b0, 3'd0, 1'b0, 2'd0);
        95: chk_out("win", c, 1'b0, 3'd0, 1'b0, 2'd0);
        default: ;
      endcase
      tick;
    end

    // Win level high at reset release fires once; async reset mid-melody
    do_reset(1'b1);
    chk_out("rstwin", 0, 1'b0, 3'd0, 1'b0, 2'd0);
    for (int c = 1; c <= 27; c++) begin
      tick;
      if (c == 1)  chk_out("rstwin", c, 1'b1, 3'd4, 1'b0, 2'd0);
      if (c == 27) chk_out("rstwin", c, 1'b1, 3'd4, 1'b1, 2'd1);
    end
    #3 rst = 1'b1;
    #1 chk_out("async_rst", 27, 1'b0, 3'd0, 1'b0, 2'd0);
    tick;
    chk_out("async_rst_hold", 28, 1'b0, 3'd0, 1'b0, 2'd0);
    rst = 1'b0;
    tick;
    chk_out("rst_release_win", 1, 1'b1, 3'd4, 1'b0, 2'd0);
    sif.p1_win = 1'b0;

    // Mute mid-goal with hit pending; events and win rise during mute ignored
    do_reset(1'b0);
    for (int c = 0; c <= 40; c++) begin
      sif.hit  = 1'b0;
      sif.goal = 1'b0;
      if (c == 2)  sif.goal = 1'b1;
      if (c == 10) sif.hit = 1'b1;
      if (c == 20) sif.sound_en = 1'b0;
      if (c == 22) begin
        sif.hit    = 1'b1;
        sif.p2_win = 1'b1;
      end
      if (c == 24) sif.sound_en = 1'b1;
      if (c == 3)  chk_out("mute", c, 1'b1, 3'd3, 1'b0, 2'd0);
      if (c == 20) chk_out("mute", c, 1'b1, 3'd3, 1'b1, 2'd0);
      if (c == 21) chk_out("mute", c, 1'b0, 3'd0, 1'b0, 2'd0);
      if (c >= 25) chk_out("unmute", c, 1'b0, 3'd0, 1'b0, 2'd0);
      tick;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sound_sequencer.md
Name: sound_sequencer

Overview:
- Shares the single piezo speaker output between the game event sources (wall, hit, goal, win) from the game controller.
- Arbitrates by fixed priority and queues lower-priority requests.
- Sequences each sound as a timed square-wave tone; the win sound is a 4-note melody.
- Sits between the game controller event outputs and the board speaker pin.

Parameters:
- HIT_HALF, 56818, tone half-period in clocks for hit sound (440 Hz @ 50 MHz)
- WALL_HALF, 113636, half-period for wall sound
- GOAL_HALF, 37879, half-period for goal sound
- SHORT_DUR, 2500000, duration in clocks of wall and hit sounds
- LONG_DUR, 10000000, duration of goal sound
- NOTE_DUR, 7500000, duration of each win-melody note
- GAP_DUR, 1250000, silent gap between win-melody notes

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- sound_en  in  1  0 = mute: forces idle, clears queue, ignores events
- hit  in  1  one-cycle pulse, paddle hit
- wall  in  1  one-cycle pulse, wall bounce
- goal  in  1  one-cycle pulse, point scored
- p1_win  in  1  level, player 1 has won
- p2_win  in  1  level, player 2 has won
- speaker  out  1  square-wave drive
- busy  out  1  a sound (including melody gaps) is in progress
- sound_id  out  3  active class: 0 none, 1 wall, 2 hit, 3 goal, 4 win
- note_idx  out  2  current win-melody note (0 otherwise)

Behaviour:
- Reset values:
  - speaker=0, busy=0, sound_id=0, note_idx=0.
  - pending bits=0, win_d=0, all counters 0.
  - State is IDLE.
- Win request: rising edge of (p1_win|p2_win), detected against registered win_d. A level already high when reset releases triggers once.
- Priority, highest first: win(4) > goal(3) > hit(2) > wall(1).
- States:
  - IDLE: no sound active.
  - PLAY: tone output for the current note.
  - GAP: silent interval between win notes.
- IDLE:
  - Selects the highest class from (pending | current-cycle requests).
  - On the next edge: enter PLAY, sound_id=class, counters cleared, speaker=0; the chosen pending bit is cleared.
  - Latency from request pulse to busy=1 is 1 cycle.
- Tone generation:
  - The tone counter counts 0..HALF-1; speaker toggles when the counter equals HALF-1.
  - The first toggle occurs HALF cycles after note start.
  - Win note half-periods in order: WALL_HALF, HIT_HALF, GOAL_HALF, HIT_HALF/2 (integer floor).
- Duration:
  - The duration counter counts 0..DUR-1 and busy is high for exactly DUR cycles per note.
  - On the last cycle, wall/hit/goal go to IDLE.
  - A win note goes to GAP (speaker forced 0, GAP_DUR cycles), then PLAY of note_idx+1.
  - After note 3 the win sound goes to IDLE.
- Total busy time:
  - wall/hit: SHORT_DUR.
  - goal: LONG_DUR.
  - win: 4*NOTE_DUR + 3*GAP_DUR.
- Requests while busy (PLAY/GAP), with the highest simultaneous request R:
  - R > active class: preempt. On the next edge, restart in PLAY with class R, note_idx=0, counters 0, speaker=0. The preempted sound is dropped, not queued.
  - R == active class: restart that sound from the beginning (same as preempt).
  - Any request below the resulting active class sets its pending bit. Repeat requests merge into one bit.
- Completion and queue:
  - After completion, IDLE lasts exactly one cycle with busy=0, then the highest pending class plays.
  - Preemption and retrigger take precedence over completion in the same cycle.
- Simultaneous requests in IDLE: the highest plays; the others are pended.
- sound_en=0:
  - Next edge forces IDLE and clears pending, speaker, sound_id and note_idx.
  - Requests are ignored while low.
  - win_d keeps tracking, so a win level that rose during mute does not fire on unmute.
- Asynchronous reset mid-sound: immediate return to reset values.

Test Plan (HIT_HALF=4, WALL_HALF=8, GOAL_HALF=3, SHORT_DUR=20, LONG_DUR=40, NOTE_DUR=16, GAP_DUR=4):
- Single hit pulse at cycle 10:
  - busy=1, sound_id=2 for cycles 11..30; speaker toggles at 15,19,23,27; speaker=0 and busy=0 at 31.
- Wall pulse, then goal pulse 5 cycles later:
  - goal preempts; sound_id=3 for 40 cycles; wall is not replayed; busy=0 afterwards.
- Goal pulse, then hit and wall pulses during the goal:
  - goal completes, busy=0 for 1 cycle, hit plays 20 cycles, busy=0 for 1 cycle, wall plays 20 cycles.
- p1_win held high from cycle 5:
  - busy for 76 cycles; note_idx steps 0..3 with half-periods 8,4,3,2; 4-cycle silent gaps; only one melody plays.
- hit, wall and goal pulsed in the same cycle while idle:
  - goal plays first, then hit, then wall.
- sound_en dropped mid-goal with hit pending:
  - next cycle busy=0, speaker=0, sound_id=0; after sound_en=1 nothing plays.
- rst pulsed mid-melody: outputs return to reset values immediately.
